key_debounce: RTL and testbench
===============================

# key_debounce

Per-key input conditioner between the DE2-115 push-buttons (KEY[n], active-low, bouncing, asynchronous) and the password-lock FSM. Each key is synchronised, debounced by a stability counter, and turned into a clean active-high level plus one-cycle press, release and long-press pulses. The press pulses drive the lock's digit-entry and enter inputs, so every physical press yields exactly one event.

## Interface
- N_KEYS, 3, number of independent key channels
- CNT_MAX, 500000, cycles a synchronised level must stay stable before it is accepted (10 ms at 50 MHz); legal range 2 or more
- LONG_MAX, 50000000, cycles a debounced press must be held before KEY_LONG fires (1 s at 50 MHz); must be greater than CNT_MAX

- CLK  input  1  system clock (CLOCK_50); all logic on the rising edge
- RESET  input  1  synchronous, active-low reset; sampled on the CLK rising edge
- KEY_N  input  N_KEYS  raw button inputs; asynchronous, active-low (0 = pressed)
- KEY_LVL  output  N_KEYS  debounced level; active-high (1 = pressed)
- KEY_PRESS  output  N_KEYS  one-cycle pulse on each accepted press
- KEY_RELEASE  output  N_KEYS  one-cycle pulse on each accepted release
- KEY_LONG  output  N_KEYS  one-cycle pulse, at most one per press, after the key has been held LONG_MAX cycles

## Operation
- Channels are fully independent. Each channel has the logic listed below, and nothing is shared between channels except CLK and RESET.
- Synchroniser: two flip-flops, sync1 then sync2. Both reset to 1 (released). The raw value used by the rest of the channel is the inverted sync2, so 1 means pressed.
- Debounce counter: width is $clog2(CNT_MAX) bits.
  - If the raw value equals KEY_LVL, the counter clears to 0.
  - If the raw value differs from KEY_LVL and the counter is below CNT_MAX-1, the counter increments.
  - If the raw value differs from KEY_LVL and the counter equals CNT_MAX-1, KEY_LVL toggles and the counter clears.
- Glitch rejection: a differing level lasting fewer than CNT_MAX consecutive sync2 samples never changes KEY_LVL. Any return to the old level restarts the count from 0.
- Pulses:
  - KEY_PRESS is registered and is 1 only in the first cycle in which KEY_LVL reads 1.
  - KEY_RELEASE is 1 only in the first cycle in which KEY_LVL reads 0 after having been 1.
- Hold counter: width is $clog2(LONG_MAX+1) bits.
  - It clears while KEY_LVL is 0.
  - While KEY_LVL is 1 it increments each cycle and saturates at LONG_MAX.
  - KEY_LONG is 1 for the single cycle in which the count first equals LONG_MAX.
- Simultaneous presses on different keys each produce their own pulses in the same cycle. No priority and no masking is applied.
- Reset:
  - RESET=0 at a rising edge forces sync1 and sync2 to 1, both counters to 0, and all outputs to 0.
  - A reset in the middle of a debounce or hold aborts it, and no pending pulse is emitted.
  - A key still held when RESET is released is treated as a fresh press. It yields KEY_PRESS after the normal latency and is not suppressed.

## Timing
- Reset values: KEY_LVL, KEY_PRESS, KEY_RELEASE and KEY_LONG are all 0.
- Press latency: KEY_N falls before rising edge k and then stays low. KEY_LVL and KEY_PRESS go to 1 after edge k+CNT_MAX+1, which is CNT_MAX+2 edges counting edge k. KEY_PRESS returns to 0 after the next edge.
- Release latency: the same CNT_MAX+2 edges from KEY_N rising to KEY_LVL=0 and KEY_RELEASE=1.
- Long-press: KEY_LONG=1 exactly LONG_MAX cycles after the KEY_PRESS cycle, for one cycle, provided KEY_LVL stays 1 throughout.
- KEY_LONG and KEY_PRESS never coincide, because LONG_MAX > CNT_MAX.
- Pulse spacing: press and release pulses on one channel are at least CNT_MAX cycles apart.
- All outputs are driven directly from flip-flops, with no combinational path from KEY_N.

## Test plan
The bench runs with N_KEYS=3, CNT_MAX=4 and LONG_MAX=16.
- Reset: hold RESET=0 for 3 cycles with KEY_N=3'b111 -> all outputs 0; they stay 0 for 20 cycles after RESET=1.
- Clean press of key 0: KEY_N[0] falls before edge k and stays low -> KEY_LVL[0]=1 and KEY_PRESS[0]=1 after edge k+5. KEY_PRESS[0]=0 after edge k+6. Keys 1 and 2 stay quiet.
- Bounce: toggle KEY_N[1] low-high-low with 1-, 2- and 3-cycle phases, then hold it low -> exactly one KEY_PRESS[1], 6 cycles after the final falling edge. No KEY_RELEASE[1].
- Glitch: a 3-cycle low pulse on KEY_N[2] -> KEY_LVL[2] stays 0 and no pulse is produced.
- Long-press and release: hold KEY_N[0] low for 40 cycles -> one KEY_LONG[0], 16 cycles after KEY_PRESS[0], with no second KEY_LONG. On release -> KEY_RELEASE[0] 6 cycles after KEY_N[0] rises.
- Reset mid-hold: press key 1, pulse RESET=0 for one cycle at hold count 10 while the key is still held -> no KEY_LONG. A new KEY_PRESS[1] occurs 6 cycles after RESET returns to 1.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioner: per-key two-flop synchroniser, stability-counter debounce,
// and registered press / release / long-press pulses.
module key_debounce #(
  parameter int N_KEYS   = 3,
  parameter int CNT_MAX  = 500000,
  parameter int LONG_MAX = 50000000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY_N,
  output logic [N_KEYS-1:0] KEY_LVL,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_KEYS-1:0] KEY_LONG
);

  localparam int CW = $clog2(CNT_MAX);
  localparam int HW = $clog2(LONG_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MAX);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_MAX - 1);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic          raw;
    logic          lvl;
    logic          press_p;
    logic          rel_p;
    logic          long_p;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;

    assign raw = ~sync2;

    // The pulses are set on the same edge that flips lvl, so they line up with its first new cycle.
    always_ff @(posedge CLK) begin
      if (!RESET) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        cnt     <= '0;
        lvl     <= 1'b0;
        press_p <= 1'b0;
        rel_p   <= 1'b0;
        hold    <= '0;
        long_p  <= 1'b0;
      end else begin
        sync1   <= KEY_N[g];
        sync2   <= sync1;
        press_p <= 1'b0;
        rel_p   <= 1'b0;

        if (raw == lvl) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt     <= '0;
          lvl     <= ~lvl;
          press_p <= ~lvl;
          rel_p   <= lvl;
        end else begin
          cnt <= cnt + 1'b1;
        end

        // Saturating at HOLD_MAX keeps the long pulse to one per press.
        if (!lvl) begin
          hold <= '0;
        end else if (hold != HOLD_MAX) begin
          hold <= hold + 1'b1;
        end

        long_p <= lvl && (hold == HOLD_PRE);
      end
    end

    assign KEY_LVL[g]     = lvl;
    assign KEY_PRESS[g]   = press_p;
    assign KEY_RELEASE[g] = rel_p;
    assign KEY_LONG[g]    = long_p;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected pulses with their
// cycle numbers, and a monitor pops one entry for every pulse the DUT raises.
module tb_key_debounce;

  localparam int N_KEYS   = 3;
  localparam int CNT_MAX  = 4;
  localparam int LONG_MAX = 16;
  localparam int K_PRESS  = 0;
  localparam int K_REL    = 1;
  localparam int K_LONG   = 2;

  typedef struct {
    int cyc;
    int kind;
    int key;
  } ev_t;

  logic              clk;
  logic              reset;
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_lvl;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;

  int  cyc;
  int  vectors;
  int  miscompares;
  ev_t exp_q[$];
  ev_t got;

  key_debounce #(
    .N_KEYS  (N_KEYS),
    .CNT_MAX (CNT_MAX),
    .LONG_MAX(LONG_MAX)
  ) dut (
    .CLK        (clk),
    .RESET      (reset),
    .KEY_N      (key_n),
    .KEY_LVL    (key_lvl),
    .KEY_PRESS  (key_press),
    .KEY_RELEASE(key_release),
    .KEY_LONG   (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // cyc read at a negedge equals the number of the rising edge just taken.
  always @(negedge clk) begin
    for (int k = 0; k < N_KEYS; k++) begin
      for (int t = 0; t < 3; t++) begin
        logic p;
        p = (t == K_PRESS) ? key_press[k] : (t == K_REL) ? key_release[k] : key_long[k];
        if (p === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_pulse: kind %0d key %0d at cycle %0d, required none", t, k, cyc);
          end else begin
            got = exp_q.pop_front();
            if (got.cyc != cyc || got.kind != t || got.key != k)
              $display("[TB] FAIL pulse_order: got kind %0d key %0d cycle %0d, required kind %0d key %0d cycle %0d",
                       t, k, cyc, got.kind, got.key, got.cyc);
            if (got.cyc != cyc || got.kind != t || got.key != k) miscompares++;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int key, input logic val);
    key_n[key] = val;
  endtask

  task automatic expectPulse(input int at, input int kind, input int key);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.key  = key;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [N_KEYS-1:0] act,
                             input logic [N_KEYS-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    key_n = '1;

    // Reset state and quiet idle
    waitCycles(3);
    checkOutput("reset_lvl", key_lvl, 3'b000);
    checkOutput("reset_press", key_press, 3'b000);
    checkOutput("reset_release", key_release, 3'b000);
    checkOutput("reset_long", key_long, 3'b000);
    reset = 1'b1;
    waitCycles(20);
    checkOutput("idle_lvl", key_lvl, 3'b000);
    checkOutput("idle_press", key_press, 3'b000);
    checkOutput("idle_long", key_long, 3'b000);

    // Clean press of key 0, short hold, release
    c = cyc;
    applyStimulus(0, 1'b0);
    expectPulse(c + 6, K_PRESS, 0);
    waitCycles(8);
    checkOutput("clean_lvl", key_lvl, 3'b001);
    c = cyc;
    applyStimulus(0, 1'b1);
    expectPulse(c + 6, K_REL, 0);
    waitCycles(10);
    checkOutput("clean_rel_lvl", key_lvl, 3'b000);

    // Bouncing key 1: 1 low, 2 high, then low for good
    applyStimulus(1, 1'b0);
    waitCycles(1);
    applyStimulus(1, 1'b1);
    waitCycles(2);
    c = cyc;
    applyStimulus(1, 1'b0);
    expectPulse(c + 6, K_PRESS, 1);
    waitCycles(10);
    checkOutput("bounce_lvl", key_lvl, 3'b010);
    c = cyc;
    applyStimulus(1, 1'b1);
    expectPulse(c + 6, K_REL, 1);
    waitCycles(10);

    // Three-cycle glitch on key 2 stays below the acceptance count
    applyStimulus(2, 1'b0);
    waitCycles(3);
    applyStimulus(2, 1'b1);
    waitCycles(10);
    checkOutput("glitch_lvl", key_lvl, 3'b000);

    // Long press of key 0 held 40 cycles
    c = cyc;
    applyStimulus(0, 1'b0);
    expectPulse(c + 6, K_PRESS, 0);
    expectPulse(c + 6 + LONG_MAX, K_LONG, 0);
    waitCycles(40);
    checkOutput("long_lvl", key_lvl, 3'b001);
    c = cyc;
    applyStimulus(0, 1'b1);
    expectPulse(c + 6, K_REL, 0);
    waitCycles(10);
    checkOutput("long_rel_lvl", key_lvl, 3'b000);

    // Reset pulse at hold count 10 on key 1, key still held afterwards
    c = cyc;
    applyStimulus(1, 1'b0);
    expectPulse(c + 6, K_PRESS, 1);
    waitCycles(16);
    reset = 1'b0;
    waitCycles(1);
    checkOutput("midreset_lvl", key_lvl, 3'b000);
    reset = 1'b1;
    c = cyc;
    expectPulse(c + 6, K_PRESS, 1);
    waitCycles(13);
    checkOutput("repress_lvl", key_lvl, 3'b010);
    c = cyc;
    applyStimulus(1, 1'b1);
    expectPulse(c + 6, K_REL, 1);
    waitCycles(30);

    // Every queued pulse must have been seen
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL queue_drain: %0d pulses outstanding, required 0", exp_q.size());
      while (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        $display("[TB] FAIL missing_pulse: kind %0d key %0d due cycle %0d never seen", got.kind, got.key, got.cyc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
